dual_port_ram_be: RTL and testbench
===================================

# dual_port_ram_be

Parametrised true dual-port synchronous RAM with per-byte write enables, selectable read-during-write behaviour, optional output register stage, same-address collision arbitration and a built-in memory-clear sequencer. It is the general-purpose shared-buffer primitive between two independent masters on one clock domain, replacing fixed-width 8-bit dual-port storage.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6: address bits; DEPTH = 2**ADDR_WIDTH words.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register, giving 2-cycle latency.
- RDW_MODE, 0: same-port read-during-write. 0 = read-first (old word); 1 = write-first (merged new word).
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en_a / en_b  input  1  port access request.
- we_a / we_b  input  1  write when 1 (with en), read when 0.
- be_a / be_b  input  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- addr_a / addr_b  input  ADDR_WIDTH  word address.
- din_a / din_b  input  DATA_WIDTH  write data.
- dout_a / dout_b  output  DATA_WIDTH  read data.
- valid_a / valid_b  output  1  dout carries the result of an accepted access.
- clr  input  1  start memory clear (level sampled).
- busy  output  1  clear sequence in progress.
- collision  output  1  1-cycle pulse: same-address conflict was arbitrated.

## Operation
- Accepted access on port x: en_x=1 and busy=0 at the rising edge. Otherwise the access is dropped and produces no valid.
- Write: only bytes with be_x[i]=1 are updated; be_x=0 is a legal no-op write that still returns data.
- Every accepted access, read or write, returns a word on dout_x with valid_x=1. Writes return data according to RDW_MODE.
- dout_x holds its last value when there is no accepted access; valid_x is 1 only in the result cycle.
- Collision: both ports accepted, addr_a==addr_b, and at least one port writing.
  - Both writing: per byte, A wins where be_a[i]=1; B is written where be_a[i]=0 and be_b[i]=1.
  - One port reading: the reading port returns the pre-write word.
  - collision=1 in the cycle after the conflicting edge. Two reads to the same address are not a collision.
- Clear FSM, IDLE -> CLEAR:
  - In IDLE, clr=1 moves the FSM to CLEAR. busy=1 from the next cycle.
  - In CLEAR, address counter 0..DEPTH-1 writes zero, one word per cycle.
  - After writing word DEPTH-1, return to IDLE. busy=1 for exactly DEPTH cycles.
  - clr is ignored while in CLEAR.
  - Port accesses presented on the same edge as clr (in IDLE) are still accepted.
- Address arithmetic: the clear counter is ADDR_WIDTH+1 bits wide, with terminal compare at DEPTH-1. No wrap into a second pass.

## Timing
- OUT_REG=0: access at edge N -> dout/valid valid after edge N+1.
- OUT_REG=1: access at edge N -> dout/valid valid after edge N+2. Fully pipelined: one access per port per cycle.
- collision is aligned to the first-stage result (edge N+1) regardless of OUT_REG.
- Reset (rst_n=0, asynchronous) forces:
  - dout_a=dout_b=0, valid_a=valid_b=0, collision=0, busy=0.
  - FSM to IDLE, clear counter to 0, pipeline registers to 0.
- Memory contents are not reset. Reset during CLEAR aborts it; words not yet reached keep their old contents.
- Deassertion of rst_n is synchronised externally; the first accepted access is on the first rising edge with rst_n=1.

## Test plan
- Reset, then write A addr 5 din 32'hDEADBEEF be 4'hF; read B addr 5 next cycle -> dout_b=32'hDEADBEEF, valid_b=1 at the expected latency, for OUT_REG=0 and 1.
- Partial write: word 0x11223344 at addr 9, then write 0xAABBCCDD be 4'b0101 -> read returns 0x11BB33DD.
- Simultaneous writes to addr 3:
  - A 0x000000FF be 4'b0001, B 0xFFFFFF00 be 4'b1111 -> word 0xFFFFFFFF, collision pulses once.
  - Repeat with be_b=4'b0001 -> byte0 = 0xFF (A wins).
- Read-during-write on port A addr 7 (old 0x1, new 0x2): RDW_MODE=0 -> dout_a=0x1; RDW_MODE=1 -> dout_a=0x2. Port B reading addr 7 same edge -> 0x1 in both modes.
- Fill memory, pulse clr:
  - busy high exactly 64 cycles.
  - Accesses during busy give no valid.
  - Afterwards every address reads 0.
  - clr re-asserted mid-clear has no effect.
- Assert rst_n=0 mid-clear at counter 20 -> busy=0 immediately, outputs 0. Addresses 0..19 read 0; addresses 21..63 keep their old data.

Source files
------------

// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with byte enables, selectable read-during-write,
// optional output register, same-address arbitration and a memory-clear sequencer.
module dual_port_ram_be #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    valid_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   din_b,
  output logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    valid_b,
  input  logic                    clr,
  output logic                    busy,
  output logic                    collision
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LastAddr = (ADDR_WIDTH + 1)'(Depth - 1);

  localparam logic StIdle  = 1'b0;
  localparam logic StClear = 1'b1;

  logic                  state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic                  acc_a, acc_b;
  logic                  wr_a, wr_b;
  logic                  same_addr;
  logic                  coll_d, coll_q;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] merged_a, merged_b;
  logic [DATA_WIDTH-1:0] rdata_a_d, rdata_b_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;
  logic                  vld_a_q, vld_b_q;

  // Gating with rst_n keeps the array untouched while reset is held.
  assign acc_a     = en_a & rst_n & (state_q == StIdle);
  assign acc_b     = en_b & rst_n & (state_q == StIdle);
  assign wr_a      = acc_a & we_a;
  assign wr_b      = acc_b & we_b;
  assign same_addr = (addr_a == addr_b);
  assign coll_d    = acc_a & acc_b & same_addr & (we_a | we_b);

  assign old_a = mem_q[addr_a];
  assign old_b = mem_q[addr_b];

  // Write-first returns the port's own merged word, not the other port's write.
  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NumBytes; i++) begin
      if (be_a[i]) merged_a[8*i +: 8] = din_a[8*i +: 8];
      if (be_b[i]) merged_b[8*i +: 8] = din_b[8*i +: 8];
    end
    rdata_a_d = ((RDW_MODE != 0) && we_a) ? merged_a : old_a;
    rdata_b_d = ((RDW_MODE != 0) && we_b) ? merged_b : old_b;
  end

  // Port A owns any byte it enables when both ports write the same word.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end
    for (int i = 0; i < NumBytes; i++) begin
      if (wr_b && be_b[i] && !(wr_a && be_a[i] && same_addr)) begin
        mem_q[addr_b][8*i +: 8] <= din_b[8*i +: 8];
      end
      if (wr_a && be_a[i]) begin
        mem_q[addr_a][8*i +: 8] <= din_a[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      vld_a_q   <= 1'b0;
      vld_b_q   <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_a_q <= acc_a;
      vld_b_q <= acc_b;
      coll_q  <= coll_d;
      if (acc_a) rdata_a_q <= rdata_a_d;
      if (acc_b) rdata_b_q <= rdata_b_d;
    end
  end

  assign busy      = (state_q == StClear);
  assign collision = coll_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;
    logic                  valid_a_q, valid_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_a_q  <= '0;
        dout_b_q  <= '0;
        valid_a_q <= 1'b0;
        valid_b_q <= 1'b0;
      end else begin
        valid_a_q <= vld_a_q;
        valid_b_q <= vld_b_q;
        if (vld_a_q) dout_a_q <= rdata_a_q;
        if (vld_b_q) dout_b_q <= rdata_b_q;
      end
    end

    assign dout_a  = dout_a_q;
    assign dout_b  = dout_b_q;
    assign valid_a = valid_a_q;
    assign valid_b = valid_b_q;
  end else begin : g_no_out_reg
    assign dout_a  = rdata_a_q;
    assign dout_b  = rdata_b_q;
    assign valid_a = vld_a_q;
    assign valid_b = vld_b_q;
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: dut0 is 1-cycle read-first, dut1 is 2-cycle write-first; both share stimulus.
module tb_dual_port_ram_be;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en_a, we_a, en_b, we_b, clr;
  logic [3:0]  be_a, be_b;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic        valid_a0, valid_b0, valid_a1, valid_b1;
  logic        busy0, busy1, coll0, coll1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dual_port_ram_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .OUT_REG(0), .RDW_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a0), .valid_a(valid_a0),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b0), .valid_b(valid_b0),
    .clr(clr), .busy(busy0), .collision(coll0)
  );

  dual_port_ram_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .OUT_REG(1), .RDW_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a1), .valid_a(valid_a1),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b1), .valid_b(valid_b1),
    .clr(clr), .busy(busy1), .collision(coll1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; be_a = '0; addr_a = '0; din_a = '0;
    en_b = 0; we_b = 0; be_b = '0; addr_b = '0; din_b = '0;
    clr  = 0;
  endtask

  task automatic wr_a(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    en_a = 1; we_a = 1; addr_a = a; din_a = d; be_a = be;
  endtask

  task automatic wr_b(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    en_b = 1; we_b = 1; addr_b = a; din_b = d; be_b = be;
  endtask

  task automatic rd_a(input logic [5:0] a);
    en_a = 1; we_a = 0; addr_a = a; be_a = '0;
  endtask

  task automatic rd_b(input logic [5:0] a);
    en_b = 1; we_b = 0; addr_b = a; be_b = '0;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 32; i++) begin
      idle();
      wr_a(6'(i), base + 32'(i), 4'hF);
      wr_b(6'(i + 32), base + 32'(i + 32), 4'hF);
      cyc();
    end
    idle();
  endtask

  function automatic logic [31:0] exp_word(input int i, input logic [31:0] base, input int zero_upto);
    return (i < zero_upto) ? 32'h0 : base + 32'(i);
  endfunction

  // Reads every address on port A; addr == zero_upto is left unchecked (partially cleared word).
  task automatic read_sweep(input logic [31:0] base, input int zero_upto);
    logic [31:0] exp;
    for (int i = 0; i < 64; i++) begin
      idle();
      rd_a(6'(i));
      cyc();
      if (i != zero_upto) begin
        exp = exp_word(i, base, zero_upto);
        total++;
        if (dout_a0 !== exp || valid_a0 !== 1'b1) begin
          bad++;
          $display("FAIL sweep_dut0 addr=%0d got %h/%b want %h/1", i, dout_a0, valid_a0, exp);
        end
      end
      if (i > 0 && (i - 1) != zero_upto) begin
        exp = exp_word(i - 1, base, zero_upto);
        total++;
        if (dout_a1 !== exp) begin
          bad++;
          $display("FAIL sweep_dut1 addr=%0d got %h want %h", i - 1, dout_a1, exp);
        end
      end
    end
    idle();
    cyc();
    exp = exp_word(63, base, zero_upto);
    total++;
    if (dout_a1 !== exp) begin
      bad++;
      $display("FAIL sweep_dut1 addr=63 got %h want %h", dout_a1, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    #2 rst_n = 0;
    cyc();
    cyc();
    total++;
    if ({dout_a0, dout_b0, valid_a0, valid_b0, busy0, coll0} !== '0) begin
      bad++;
      $display("FAIL reset_dut0 got %h %h %b%b%b%b want all 0",
               dout_a0, dout_b0, valid_a0, valid_b0, busy0, coll0);
    end
    total++;
    if ({dout_a1, dout_b1, valid_a1, valid_b1, busy1, coll1} !== '0) begin
      bad++;
      $display("FAIL reset_dut1 got %h %h %b%b%b%b want all 0",
               dout_a1, dout_b1, valid_a1, valid_b1, busy1, coll1);
    end
    rst_n = 1;
  endtask

  task automatic test_basic();
    idle(); wr_a(6'd5, 32'hDEADBEEF, 4'hF); cyc();
    total++;
    if (valid_a0 !== 1'b1) begin bad++; $display("FAIL basic_wr_valid0 got %b want 1", valid_a0); end
    idle(); rd_b(6'd5); cyc();
    total++;
    if (dout_b0 !== 32'hDEADBEEF || valid_b0 !== 1'b1) begin
      bad++; $display("FAIL basic_rd_dut0 got %h/%b want deadbeef/1", dout_b0, valid_b0);
    end
    total++;
    if (dout_a1 !== 32'hDEADBEEF || valid_a1 !== 1'b1) begin
      bad++; $display("FAIL basic_wr_dut1 got %h/%b want deadbeef/1", dout_a1, valid_a1);
    end
    total++;
    if (valid_b1 !== 1'b0) begin bad++; $display("FAIL basic_latency_dut1 got %b want 0", valid_b1); end
    idle(); cyc();
    total++;
    if (dout_b1 !== 32'hDEADBEEF || valid_b1 !== 1'b1) begin
      bad++; $display("FAIL basic_rd_dut1 got %h/%b want deadbeef/1", dout_b1, valid_b1);
    end
    total++;
    if (dout_b0 !== 32'hDEADBEEF || valid_b0 !== 1'b0) begin
      bad++; $display("FAIL basic_hold_dut0 got %h/%b want deadbeef/0", dout_b0, valid_b0);
    end
  endtask

  task automatic test_partial();
    idle(); wr_a(6'd9, 32'h11223344, 4'hF); cyc();
    idle(); wr_a(6'd9, 32'hAABBCCDD, 4'b0101); cyc();
    total++;
    if (dout_a0 !== 32'h11223344) begin
      bad++; $display("FAIL partial_rdfirst got %h want 11223344", dout_a0);
    end
    idle(); rd_a(6'd9); cyc();
    total++;
    if (dout_a0 !== 32'h11BB33DD) begin
      bad++; $display("FAIL partial_read_dut0 got %h want 11bb33dd", dout_a0);
    end
    total++;
    if (dout_a1 !== 32'h11BB33DD) begin
      bad++; $display("FAIL partial_wrfirst got %h want 11bb33dd", dout_a1);
    end
    idle(); cyc();
    total++;
    if (dout_a1 !== 32'h11BB33DD || valid_a1 !== 1'b1) begin
      bad++; $display("FAIL partial_read_dut1 got %h/%b want 11bb33dd/1", dout_a1, valid_a1);
    end
  endtask

  task automatic test_collision();
    idle(); wr_a(6'd3, 32'h0, 4'hF); cyc();
    idle(); wr_a(6'd3, 32'h000000FF, 4'b0001); wr_b(6'd3, 32'hFFFFFF00, 4'b1111); cyc();
    total++;
    if (coll0 !== 1'b1 || coll1 !== 1'b1) begin
      bad++; $display("FAIL coll_pulse got %b%b want 11", coll0, coll1);
    end
    idle(); rd_a(6'd3); cyc();
    total++;
    if (coll0 !== 1'b0) begin bad++; $display("FAIL coll_once got %b want 0", coll0); end
    total++;
    if (dout_a0 !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL coll_merge got %h want ffffffff", dout_a0);
    end
    idle(); wr_a(6'd3, 32'h0, 4'hF); cyc();
    idle(); wr_a(6'd3, 32'h000000FF, 4'b0001); wr_b(6'd3, 32'hFFFFFF00, 4'b0001); cyc();
    idle(); rd_a(6'd3); rd_b(6'd3); cyc();
    total++;
    if (dout_a0 !== 32'h000000FF) begin
      bad++; $display("FAIL coll_a_wins got %h want 000000ff", dout_a0);
    end
    idle(); cyc();
    total++;
    if (coll0 !== 1'b0 || dout_b0 !== 32'h000000FF) begin
      bad++; $display("FAIL coll_two_reads got coll=%b dout_b=%h want 0/000000ff", coll0, dout_b0);
    end
  endtask

  task automatic test_rdw();
    idle(); wr_a(6'd7, 32'h1, 4'hF); cyc();
    idle(); wr_a(6'd7, 32'h2, 4'hF); rd_b(6'd7); cyc();
    total++;
    if (dout_a0 !== 32'h1 || dout_b0 !== 32'h1) begin
      bad++; $display("FAIL rdw_readfirst got a=%h b=%h want 1/1", dout_a0, dout_b0);
    end
    total++;
    if (coll0 !== 1'b1 || coll1 !== 1'b1) begin
      bad++; $display("FAIL rdw_coll got %b%b want 11", coll0, coll1);
    end
    idle(); cyc();
    total++;
    if (dout_a1 !== 32'h2 || dout_b1 !== 32'h1) begin
      bad++; $display("FAIL rdw_writefirst got a=%h b=%h want 2/1", dout_a1, dout_b1);
    end
  endtask

  task automatic test_clear();
    int n;
    int vbad;
    fill(32'h100);
    idle(); clr = 1; rd_a(6'd1); cyc();
    total++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      bad++; $display("FAIL clr_busy_start got %b%b want 11", busy0, busy1);
    end
    total++;
    if (valid_a0 !== 1'b1 || dout_a0 !== 32'h101) begin
      bad++; $display("FAIL clr_same_edge_access got %h/%b want 00000101/1", dout_a0, valid_a0);
    end
    clr = 0; rd_a(6'd1); rd_b(6'd2);
    n = 1;
    vbad = 0;
    for (int k = 0; k < 200; k++) begin
      clr = (n == 30);
      cyc();
      if (!busy0) break;
      n++;
      if (valid_a0 || valid_b0) vbad++;
      if (k > 0 && (valid_a1 || valid_b1)) vbad++;
    end
    idle();
    total++;
    if (n !== 64) begin bad++; $display("FAIL clr_busy_len got %0d want 64", n); end
    total++;
    if (vbad !== 0) begin bad++; $display("FAIL clr_no_valid got %0d want 0", vbad); end
    total++;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL clr_busy_end_dut1 got %b want 0", busy1); end
    cyc();
    read_sweep(32'h0, 64);
  endtask

  task automatic test_reset_mid_clear();
    fill(32'h200);
    clr = 1; cyc();
    clr = 0;
    for (int k = 0; k < 20; k++) cyc();
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL rmc_busy_before got %b want 1", busy0); end
    #1 rst_n = 0;
    #1;
    total++;
    if ({busy0, busy1, valid_a0, valid_b0, valid_a1, valid_b1, coll0, coll1} !== '0) begin
      bad++; $display("FAIL rmc_flags got %b%b%b%b%b%b%b%b want all 0",
                      busy0, busy1, valid_a0, valid_b0, valid_a1, valid_b1, coll0, coll1);
    end
    total++;
    if ({dout_a0, dout_b0, dout_a1, dout_b1} !== '0) begin
      bad++; $display("FAIL rmc_dout got %h %h %h %h want all 0", dout_a0, dout_b0, dout_a1, dout_b1);
    end
    @(posedge clk);
    #1 rst_n = 1;
    read_sweep(32'h200, 20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_collision();
    test_rdw();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
